// File: rtl/conv_result_writer.sv
// Write-back DMA: buffers engine pixels in a small FIFO and streams them to RAM from a base address.
// Optional build macro CONV_RESULT_WRITER_RELU_EN rectifies negative pixels as they enter the FIFO.
`timescale 1ns/1ps
module conv_result_writer #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_SIZE   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_address,
    input  logic [5:0]        out_size,
    input  logic [DATA_W-1:0] pixel_in,
    input  logic              pixel_valid,
    output logic              pixel_ready,
    output logic [ADDR_W-1:0] RAM_address,
    output logic [DATA_W-1:0] RAM_data,
    output logic              RAM_write,
    input  logic              RAM_busy,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a pixel transfers on a rising edge where pixel_valid & pixel_ready;
    // pixel_ready is decoded from registered state only and never looks at pixel_valid.
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    state_t state, state_nxt;

    logic [ADDR_W-1:0] base_q;
    logic [10:0]       total_q, accepted_q, written_q, issued_q;
    logic [5:0]        size_clamped;
    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full, fifo_empty, push, pop, out_fire;
    logic [DATA_W-1:0] pixel_entry;

    assign size_clamped = (out_size > 6'(MAX_SIZE)) ? 6'(MAX_SIZE) : out_size;
    assign fifo_full    = (fifo_count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty   = (fifo_count == '0);
    assign pixel_ready  = (state == S_RUN) && !fifo_full && (accepted_q < total_q);
    assign push         = pixel_valid && pixel_ready;
    assign out_fire     = RAM_write && !RAM_busy;
    // Output register refills from the FIFO head whenever it is empty or its write completes.
    assign pop          = !fifo_empty && (!RAM_write || out_fire);
    assign busy         = (state == S_RUN) || (state == S_DRAIN);
    assign done         = (state == S_DONE);
    assign dbg_state    = state;

`ifdef CONV_RESULT_WRITER_RELU_EN
    assign pixel_entry = pixel_in[DATA_W-1] ? '0 : pixel_in;
`else
    assign pixel_entry = pixel_in;
`endif

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= pixel_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            base_q      <= '0;
            total_q     <= '0;
            accepted_q  <= '0;
            written_q   <= '0;
            issued_q    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_count  <= '0;
            RAM_write   <= 1'b0;
            RAM_address <= '0;
            RAM_data    <= '0;
        end else begin
            state <= state_nxt;
            if (push) begin
                wr_ptr     <= wr_ptr + PTR_W'(1);
                accepted_q <= accepted_q + 11'd1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (pop) begin
                rd_ptr      <= rd_ptr + PTR_W'(1);
                RAM_write   <= 1'b1;
                RAM_data    <= fifo_mem[rd_ptr];
                RAM_address <= base_q + ADDR_W'(issued_q);
                issued_q    <= issued_q + 11'd1;
            end else if (out_fire) begin
                RAM_write <= 1'b0;
            end
            if (out_fire) written_q <= written_q + 11'd1;
            if (state == S_IDLE && start) begin
                base_q     <= base_address;
                total_q    <= 11'(size_clamped) * 11'(size_clamped);
                accepted_q <= '0;
                written_q  <= '0;
                issued_q   <= '0;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = (size_clamped == '0) ? S_DONE : S_RUN;
            S_RUN:   if (accepted_q == total_q) state_nxt = S_DRAIN;
            // Leave as soon as the final write completes so done follows it directly.
            S_DRAIN: if ((written_q == total_q) ||
                         (out_fire && (written_q + 11'd1 == total_q))) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_conv_result_writer.sv
// Directed bench for conv_result_writer: queue-level reference model checked every cycle plus literal write logs.
`timescale 1ns/1ps
module tb_conv_result_writer;
  localparam int DEPTH = 4;

  logic        clk, rst, start, pixel_valid, pixel_ready, RAM_write, RAM_busy, busy, done;
  logic [15:0] base_address, pixel_in, RAM_address, RAM_data;
  logic [5:0]  out_size;
  logic [1:0]  dbg_state;

  conv_result_writer dut (
    .clk(clk), .rst(rst), .start(start), .base_address(base_address), .out_size(out_size),
    .pixel_in(pixel_in), .pixel_valid(pixel_valid), .pixel_ready(pixel_ready),
    .RAM_address(RAM_address), .RAM_data(RAM_data), .RAM_write(RAM_write),
    .RAM_busy(RAM_busy), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] rect(input logic [15:0] p);
`ifdef CONV_RESULT_WRITER_RELU_EN
    return p[15] ? 16'h0000 : p;
`else
    return p;
`endif
  endfunction

  // reference model: frame phase 0=idle 1=active 2=done-pulse
  int          m_phase = 0, m_total = 0, m_acc = 0, m_wr = 0, m_issue = 0;
  logic [15:0] m_base = '0;
  logic [15:0] m_pend[$];
  logic        m_out_v = 1'b0;
  logic [15:0] m_out_a = '0, m_out_d = '0;
  logic        exp_ready, m_fire, m_push;
  int          old_phase, sz;

  // observed write / done logs
  logic [15:0] wlog_a[$], wlog_d[$];
  int          wlog_c[$], done_cyc[$];

  always @(negedge clk) begin
    cyc++;
    exp_ready = (m_phase == 1) && (m_pend.size() < DEPTH) && (m_acc < m_total);
    if (chk_en) begin
      chk("pixel_ready", pixel_ready, exp_ready);
      chk("RAM_write", RAM_write, m_out_v);
      if (m_out_v) begin
        chk("RAM_address", RAM_address, m_out_a);
        chk("RAM_data", RAM_data, m_out_d);
      end
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_phase == 2);
    end
    if (RAM_write === 1'b1 && RAM_busy === 1'b0 && rst === 1'b0) begin
      wlog_a.push_back(RAM_address);
      wlog_d.push_back(RAM_data);
      wlog_c.push_back(cyc);
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (rst) begin
      m_phase = 0; m_total = 0; m_acc = 0; m_wr = 0; m_issue = 0; m_base = '0;
      m_pend.delete(); m_out_v = 1'b0; m_out_a = '0; m_out_d = '0;
    end else begin
      old_phase = m_phase;
      m_fire = m_out_v && !RAM_busy;
      m_push = pixel_valid && exp_ready;
      if (m_phase == 0 && start) begin
        sz = (out_size > 6'd32) ? 32 : int'(out_size);
        m_base = base_address; m_total = sz * sz;
        m_acc = 0; m_wr = 0; m_issue = 0;
        m_phase = (sz == 0) ? 2 : 1;
      end else if (m_phase == 2) begin
        m_phase = 0;
      end
      if (m_pend.size() > 0 && (!m_out_v || m_fire)) begin
        m_out_d = m_pend.pop_front();
        m_out_a = m_base + 16'(m_issue);
        m_issue++;
        m_out_v = 1'b1;
      end else if (m_fire) begin
        m_out_v = 1'b0;
      end
      if (m_fire) m_wr++;
      if (m_push) begin
        m_pend.push_back(rect(pixel_in));
        m_acc++;
      end
      if (old_phase == 1 && m_wr == m_total) m_phase = 2;
    end
  end

  // pixel source driver
  logic [15:0] src_q[$];
  int          n_acc = 0;
  logic        drv_acc;

  initial begin
    pixel_valid = 1'b0;
    pixel_in = '0;
    forever begin
      @(negedge clk);
      drv_acc = pixel_valid && pixel_ready && !rst;
      @(posedge clk);
      #1;
      if (drv_acc && src_q.size() > 0) begin
        void'(src_q.pop_front());
        n_acc++;
      end
      if (src_q.size() > 0) begin
        pixel_valid = 1'b1;
        pixel_in = src_q[0];
      end else begin
        pixel_valid = 1'b0;
      end
    end
  end

  int s_cyc;

  task automatic clear_logs();
    wlog_a.delete(); wlog_d.delete(); wlog_c.delete(); done_cyc.delete();
  endtask

  task automatic start_frame(input logic [15:0] b, input logic [5:0] s);
    @(posedge clk); #2;
    base_address = b; out_size = s; start = 1'b1;
    @(negedge clk); #1;
    s_cyc = cyc;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    logic got;
    got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, got, 1'b1);
  endtask

  task automatic check_writes(input string tag, input logic [15:0] a0, input logic [15:0] dq[$]);
    logic [15:0] ea;
    chk({tag, "_count"}, wlog_a.size(), dq.size());
    for (int i = 0; i < dq.size(); i++) begin
      if (i < wlog_a.size()) begin
        ea = a0 + 16'(i);
        chk($sformatf("%s_addr%0d", tag, i), wlog_a[i], ea);
        chk($sformatf("%s_data%0d", tag, i), wlog_d[i], dq[i]);
      end
    end
  endtask

  logic [15:0] exp_d[$];
  logic        seen;
  int          hold;

  initial begin
    rst = 1'b1; start = 1'b0; base_address = '0; out_size = '0; RAM_busy = 1'b0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    @(negedge clk); #1;
    chk("reset_RAM_write", RAM_write, 1'b0);
    chk("reset_RAM_address", RAM_address, 16'h0000);
    chk("reset_RAM_data", RAM_data, 16'h0000);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_pixel_ready", pixel_ready, 1'b0);
    @(posedge clk); #2;
    rst = 1'b0;

    // basic frame, one extra pixel left pending
    clear_logs(); n_acc = 0;
    for (int i = 1; i <= 5; i++) src_q.push_back(16'(i));
    start_frame(16'h0100, 6'd2);
    wait_done("basic", 50);
    exp_d = {16'h0001, 16'h0002, 16'h0003, 16'h0004};
    check_writes("basic", 16'h0100, exp_d);
    if (wlog_c.size() == 4) begin
      for (int i = 1; i < 4; i++) chk($sformatf("basic_back_to_back%0d", i), wlog_c[i], wlog_c[0] + i);
      if (done_cyc.size() > 0) chk("basic_done_after_last_write", done_cyc[0], wlog_c[3] + 1);
    end
    chk("basic_busy_with_done", busy, 1'b0);
    repeat (3) @(negedge clk);
    #1;
    chk("basic_single_done", done_cyc.size(), 1);
    chk("basic_accepted", n_acc, 4);
    chk("extra_pixel_pending", pixel_valid, 1'b1);

    // RAM stall on second write, size 3 so the FIFO fills
    clear_logs();
    for (int i = 6; i <= 13; i++) src_q.push_back(16'(i));
    start_frame(16'h0100, 6'd3);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk); #1;
      if (RAM_write === 1'b1 && RAM_address === 16'h0100) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stall_first_write_seen", seen, 1'b1);
    @(posedge clk); #2;
    RAM_busy = 1'b1;
    hold = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      if (RAM_write === 1'b1 && RAM_address === 16'h0101 && RAM_data === 16'h0006) hold++;
    end
    @(posedge clk); #2;
    RAM_busy = 1'b0;
    chk("stall_hold_cycles", hold, 3);
    @(negedge clk); #1;
    chk("stall_fifo_full_ready", pixel_ready, 1'b0);
    wait_done("stall", 100);
    exp_d.delete();
    for (int i = 0; i < 9; i++) exp_d.push_back(16'(5 + i));
    check_writes("stall", 16'h0100, exp_d);

    // address wrap
    clear_logs();
    exp_d = {16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4};
    for (int i = 0; i < 4; i++) src_q.push_back(exp_d[i]);
    start_frame(16'hFFFE, 6'd2);
    wait_done("wrap", 50);
    check_writes("wrap", 16'hFFFE, exp_d);
    if (wlog_a.size() == 4) begin
      chk("wrap_addr2_literal", wlog_a[2], 16'h0000);
      chk("wrap_addr3_literal", wlog_a[3], 16'h0001);
    end

    // zero size
    clear_logs();
    start_frame(16'h1234, 6'd0);
    wait_done("zero", 10);
    if (done_cyc.size() > 0) chk("zero_done_timing", done_cyc[0], s_cyc + 1);
    repeat (3) @(negedge clk);
    #1;
    chk("zero_no_writes", wlog_a.size(), 0);
    chk("zero_single_done", done_cyc.size(), 1);

    // reset mid-frame after 2 of 9 pixels
    clear_logs(); n_acc = 0;
    for (int i = 0; i < 9; i++) src_q.push_back(16'h0100 + 16'(i));
    start_frame(16'h0200, 6'd3);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #2;
      if (n_acc >= 2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("reset_two_accepted", seen, 1'b1);
    rst = 1'b1;
    src_q.delete();
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk); #1;
    chk("abort_RAM_write", RAM_write, 1'b0);
    chk("abort_RAM_address", RAM_address, 16'h0000);
    chk("abort_RAM_data", RAM_data, 16'h0000);
    chk("abort_busy", busy, 1'b0);
    repeat (8) @(negedge clk);
    #1;
    chk("abort_no_done", done_cyc.size(), 0);

    // new frame from new base; start pulsed mid-run is ignored
    clear_logs();
    exp_d = {16'h00C1, 16'h00C2, 16'h00C3, 16'h00C4};
    for (int i = 0; i < 4; i++) src_q.push_back(exp_d[i]);
    start_frame(16'h0300, 6'd2);
    base_address = 16'h0500; out_size = 6'd5; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    wait_done("restart", 50);
    check_writes("restart", 16'h0300, exp_d);

    // clamp to 32x32
    clear_logs();
    exp_d.delete();
    for (int i = 0; i < 1024; i++) begin
      src_q.push_back(16'(i));
      exp_d.push_back(16'(i));
    end
    start_frame(16'h2000, 6'd40);
    wait_done("clamp", 1300);
    check_writes("clamp", 16'h2000, exp_d);
    chk("clamp_total_literal", wlog_a.size(), 1024);

    // rectification
    clear_logs();
    exp_d = {16'hFFF0, 16'h0005, 16'h8000, 16'h7FFF};
    for (int i = 0; i < 4; i++) src_q.push_back(exp_d[i]);
`ifdef CONV_RESULT_WRITER_RELU_EN
    exp_d = {16'h0000, 16'h0005, 16'h0000, 16'h7FFF};
`endif
    start_frame(16'h0400, 6'd2);
    wait_done("relu", 50);
    check_writes("relu", 16'h0400, exp_d);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
